// File: rtl/pc_ctrl_pkg.sv
// Shared FSM state, exception cause codes and vector base for the PC control unit.
// Pure declarations; no latency, no flow control.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SAVE  = 2'd1,
        ST_FETCH = 2'd2
    } pc_state_e;

    localparam logic [1:0] CAUSE_OPCODE = 2'd0;
    localparam logic [1:0] CAUSE_OVF    = 2'd1;
    localparam logic [1:0] CAUSE_DIV0   = 2'd2;

    localparam int unsigned VEC_BASE = 253;

    // Lowest set request bit wins: opcode over overflow over divide-by-zero.
    function automatic logic [1:0] exc_cause(input logic [2:0] req);
        if (req[0])      return CAUSE_OPCODE;
        else if (req[1]) return CAUSE_OVF;
        else             return CAUSE_DIV0;
    endfunction

endpackage

// File: rtl/pc_src_mux_n.sv
// N-way PC source select; out-of-range select yields zero and drops o_sel_ok.
// Combinational, zero latency, no flow control.
module pc_src_mux_n
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC*WIDTH-1:0] i_src_bus,
    input  logic [SEL_W-1:0]         i_sel,
    output logic [WIDTH-1:0]         o_mux_out,
    output logic                     o_sel_ok
);

    always_comb begin
        o_mux_out = '0;
        o_sel_ok  = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (32'(i_sel) == k) begin
                o_mux_out = i_src_bus[k*WIDTH +: WIDTH];
                o_sel_ok  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_control_unit.sv
// Program counter with muxed loads, eret and a SAVE/FETCH exception vector sequence.
// Loads land one edge after request; exceptions take 2 cycles plus vector-read wait; inputs ignored while busy.
module pc_control_unit
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned     WIDTH    = 32,
    parameter int unsigned     NUM_SRC  = 8,
    parameter int unsigned     SEL_W    = $clog2(NUM_SRC),
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_SRC*WIDTH-1:0] src_bus,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     pc_write,
    input  logic                     pc_write_cond,
    input  logic                     cond,
    input  logic [2:0]               exc_req,
    input  logic                     eret,
    input  logic                     vec_ack,
    input  logic [7:0]               vec_data,
    output logic [WIDTH-1:0]         mux_out,
    output logic [WIDTH-1:0]         pc,
    output logic [WIDTH-1:0]         epc,
    output logic [1:0]               cause,
    output logic                     vec_req,
    output logic [WIDTH-1:0]         vec_addr,
    output logic                     busy,
    output logic                     sel_err
);

    pc_state_e        r_state;
    pc_state_e        w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic [1:0]       r_cause;
    logic             r_sel_err;
    logic             w_sel_ok;
    logic             w_write;
    logic             w_exc;

    pc_src_mux_n #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_src_mux (
        .i_src_bus (src_bus),
        .i_sel     (sel),
        .o_mux_out (mux_out),
        .o_sel_ok  (w_sel_ok)
    );

    assign w_write = pc_write | (pc_write_cond & cond);
    assign w_exc   = |exc_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_exc)   w_state_nxt = ST_SAVE;
            ST_SAVE:               w_state_nxt = ST_FETCH;
            ST_FETCH: if (vec_ack) w_state_nxt = ST_IDLE;
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != ST_IDLE);
        vec_req = (r_state == ST_FETCH);
    end

    // An exception in IDLE outranks any simultaneous write or eret; pc holds that edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc      <= RESET_PC;
            r_epc     <= '0;
            r_cause   <= CAUSE_OPCODE;
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_exc) begin
                        r_cause <= exc_cause(exc_req);
                    end else if (w_write) begin
                        if (w_sel_ok) r_pc      <= mux_out;
                        else          r_sel_err <= 1'b1;
                    end else if (eret) begin
                        r_pc <= r_epc;
                    end
                end
                ST_SAVE:  r_epc <= r_pc - WIDTH'(4);
                ST_FETCH: if (vec_ack) r_pc <= WIDTH'(vec_data);
                default: ;
            endcase
        end
    end

    assign pc       = r_pc;
    assign epc      = r_epc;
    assign cause    = r_cause;
    assign sel_err  = r_sel_err;
    assign vec_addr = WIDTH'(VEC_BASE) + WIDTH'(r_cause);

endmodule

// File: tb/tb_pc_control_unit.sv
// Randomized and directed bench for pc_control_unit against a transaction-level model.
module tb_pc_control_unit;

    localparam int          W   = 32;
    localparam int          N   = 5;
    localparam int          SW  = 3;
    localparam logic [31:0] RPC = 32'h0000_0010;

    logic          clk;
    logic          reset_n;
    logic [N*W-1:0] src_bus;
    logic [SW-1:0] sel;
    logic          pc_write, pc_write_cond, cond, eret, vec_ack;
    logic [2:0]    exc_req;
    logic [7:0]    vec_data;
    logic [W-1:0]  mux_out, pc, epc, vec_addr;
    logic [1:0]    cause;
    logic          vec_req, busy, sel_err;

    int checks   = 0;
    int failures = 0;

    pc_control_unit #(
        .WIDTH    (W),
        .NUM_SRC  (N),
        .SEL_W    (SW),
        .RESET_PC (RPC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .src_bus       (src_bus),
        .sel           (sel),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .cond          (cond),
        .exc_req       (exc_req),
        .eret          (eret),
        .vec_ack       (vec_ack),
        .vec_data      (vec_data),
        .mux_out       (mux_out),
        .pc            (pc),
        .epc           (epc),
        .cause         (cause),
        .vec_req       (vec_req),
        .vec_addr      (vec_addr),
        .busy          (busy),
        .sel_err       (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] src_of(input int k);
        return src_bus[k*W +: W];
    endfunction

    // Model: phase 0 = ready, 1 = saving return address, 2 = waiting on vector memory.
    logic [31:0] m_pc    = RPC;
    logic [31:0] m_epc   = '0;
    logic [1:0]  m_cause = '0;
    int          m_phase = 0;
    logic        m_err   = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pc = RPC; m_epc = '0; m_cause = '0; m_phase = 0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_phase == 0) begin
                if (exc_req != 3'b000) begin
                    for (int i = 2; i >= 0; i--) if (exc_req[i]) m_cause = 2'(i);
                    m_phase = 1;
                end else if (pc_write || (pc_write_cond && cond)) begin
                    if (int'(sel) < N) m_pc = src_of(int'(sel));
                    else               m_err = 1'b1;
                end else if (eret) begin
                    m_pc = m_epc;
                end
            end else if (m_phase == 1) begin
                m_epc   = m_pc - 32'd4;
                m_phase = 2;
            end else if (vec_ack) begin
                m_pc    = {24'd0, vec_data};
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("mux_out",  mux_out, (int'(sel) < N) ? src_of(int'(sel)) : 32'd0);
        chk("pc",       pc, m_pc);
        chk("epc",      epc, m_epc);
        chk("cause",    32'(cause), 32'(m_cause));
        chk("vec_addr", vec_addr, 32'd253 + 32'(m_cause));
        chk("busy",     32'(busy), 32'(m_phase != 0));
        chk("vec_req",  32'(vec_req), 32'(m_phase == 2));
        chk("sel_err",  32'(sel_err), 32'(m_err));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        pc_write = 0; pc_write_cond = 0; cond = 0; eret = 0;
        exc_req = 3'b000; vec_ack = 0; vec_data = 8'h00;
    endtask

    task automatic set_src(input int k, input logic [31:0] v);
        src_bus[k*W +: W] = v;
    endtask

    initial begin
        reset_n = 1'b1;
        src_bus = '0;
        sel     = '0;
        quiet();
        #1 reset_n = 1'b0;
        #1;
        chk("rst_pc", pc, RPC);
        chk("rst_epc", epc, 32'd0);
        chk("rst_cause", 32'(cause), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vec_req", 32'(vec_req), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        step(); step();
        reset_n = 1'b1;

        // First write right after reset release.
        set_src(2, 32'h400); sel = 3'd2; pc_write = 1;
        step();
        chk("wr_pc", pc, 32'h400);
        chk("wr_sel_err", 32'(sel_err), 32'd0);

        quiet(); set_src(1, 32'h200); sel = 3'd1; pc_write_cond = 1; cond = 0;
        step();
        chk("cond0_pc", pc, 32'h400);
        cond = 1;
        step();
        chk("cond1_pc", pc, 32'h200);

        quiet(); set_src(3, 32'h100); sel = 3'd3; pc_write = 1;
        step();
        chk("pc_100", pc, 32'h100);
        quiet(); exc_req = 3'b110; pc_write = 1; eret = 1;
        step();
        chk("exc_pc_hold", pc, 32'h100);
        chk("exc_cause", 32'(cause), 32'd1);
        chk("exc_busy", 32'(busy), 32'd1);
        quiet();
        step();
        chk("exc_epc", epc, 32'h0FC);
        chk("exc_vec_addr", vec_addr, 32'd254);
        chk("exc_vec_req", 32'(vec_req), 32'd1);
        pc_write = 1; eret = 1; exc_req = 3'b001;
        step();
        chk("wait_vec_req", 32'(vec_req), 32'd1);
        chk("wait_pc", pc, 32'h100);
        step();
        chk("wait_vec_addr", vec_addr, 32'd254);
        quiet(); vec_ack = 1; vec_data = 8'h80;
        step();
        chk("ack_pc", pc, 32'h80);
        chk("ack_busy", 32'(busy), 32'd0);
        chk("ack_vec_req", 32'(vec_req), 32'd0);

        quiet(); sel = 3'd6; pc_write = 1;
        #1 chk("oor_mux", mux_out, 32'd0);
        step();
        chk("oor_pc", pc, 32'h80);
        chk("oor_sel_err", 32'(sel_err), 32'd1);
        quiet();
        step();
        chk("oor_sel_err_drop", 32'(sel_err), 32'd0);

        set_src(0, 32'h0); sel = 3'd0; pc_write = 1;
        step();
        chk("pc_zero", pc, 32'h0);
        quiet(); exc_req = 3'b001;
        step();
        quiet();
        step();
        chk("wrap_epc", epc, 32'hFFFF_FFFC);
        chk("wrap_cause", 32'(cause), 32'd0);
        vec_ack = 1; vec_data = 8'h33;
        step();
        quiet(); eret = 1;
        step();
        chk("eret_pc", pc, 32'hFFFF_FFFC);

        quiet(); exc_req = 3'b100;
        step();
        quiet();
        step();
        chk("f_vec_addr", vec_addr, 32'd255);
        reset_n = 1'b0;
        #1;
        chk("abort_vec_req", 32'(vec_req), 32'd0);
        chk("abort_pc", pc, RPC);
        vec_ack = 1; vec_data = 8'h55;
        step();
        reset_n = 1'b1;
        step();
        chk("late_ack_pc", pc, RPC);
        chk("late_ack_busy", 32'(busy), 32'd0);

        for (int it = 0; it < 600; it++) begin
            for (int k = 0; k < N; k++) set_src(k, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            sel           = SW'($urandom_range(0, 7));
            pc_write      = ($urandom_range(0, 3) == 0);
            pc_write_cond = ($urandom_range(0, 3) == 0);
            cond          = $urandom_range(0, 1) == 1;
            eret          = ($urandom_range(0, 5) == 0);
            exc_req       = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            vec_ack       = ($urandom_range(0, 2) == 0);
            vec_data      = 8'($urandom);
            reset_n       = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_control_unit.md
PC_CONTROL_UNIT -- requirements
Module: pc_control_unit

Interface
REQ-001 Parameter WIDTH, default 32, PC/data width.
REQ-002 Parameter NUM_SRC, default 8, number of PC source inputs (2..16).
REQ-003 Parameter SEL_W, default $clog2(NUM_SRC), selector width.
REQ-004 Parameter RESET_PC, default 0, PC value after reset.
REQ-005 clk  in  1  single system clock, rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 src_bus  in  NUM_SRC*WIDTH  flattened PC sources; source k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  in  SEL_W  PC source select.
REQ-009 pc_write  in  1  unconditional PC load.
REQ-010 pc_write_cond  in  1  conditional PC load (branch).
REQ-011 cond  in  1  branch condition, qualifies pc_write_cond.
REQ-012 exc_req  in  3  exception requests: [0] invalid opcode, [1] overflow, [2] divide-by-zero.
REQ-013 eret  in  1  return from exception.
REQ-014 vec_ack  in  1  memory acknowledges vector read; vec_data valid.
REQ-015 vec_data  in  8  handler address byte from memory.
REQ-016 mux_out  out  WIDTH  combinational src[sel] (0 if sel >= NUM_SRC).
REQ-017 pc  out  WIDTH  registered program counter.
REQ-018 epc  out  WIDTH  registered exception PC.
REQ-019 cause  out  2  registered cause: 0 opcode, 1 overflow, 2 div0.
REQ-020 vec_req  out  1  vector read request, held until vec_ack.
REQ-021 vec_addr  out  WIDTH  vector address, zero-extended 253 + cause.
REQ-022 busy  out  1  high whenever FSM is not IDLE.
REQ-023 sel_err  out  1  one-cycle pulse on write attempt with sel >= NUM_SRC.

Function
REQ-024 FSM states IDLE, SAVE, FETCH; IDLE->SAVE on any exc_req bit, SAVE->FETCH unconditionally, FETCH->IDLE on vec_ack.
REQ-025 In IDLE with no exc_req, pc SHALL load src[sel] one edge after (pc_write | (pc_write_cond & cond)) is high.
REQ-026 Out-of-range sel on a write SHALL leave pc unchanged and pulse sel_err the next cycle.
REQ-027 In IDLE, eret with no exc_req and no write SHALL load pc <= epc on the next edge; eret with pc_write SHALL give pc_write priority.
REQ-028 On IDLE->SAVE, cause SHALL latch the lowest set exc_req bit index (opcode > overflow > div0 priority).
REQ-029 In SAVE, epc SHALL load pc - 4, modulo 2^WIDTH (pc=0 gives all-ones minus 3).
REQ-030 In FETCH, vec_req=1 and vec_addr=253+cause SHALL be held stable until vec_ack.
REQ-031 On vec_ack in FETCH, pc SHALL load zero-extended vec_data and vec_req SHALL drop the same edge.
REQ-032 Exception in IDLE SHALL take priority over simultaneous pc_write/eret; pc SHALL not change that edge.
REQ-033 While busy, pc_write, pc_write_cond, eret and new exc_req SHALL be ignored (not queued).
REQ-034 vec_ack outside FETCH SHALL be ignored.
REQ-035 Total exception latency SHALL be 2 cycles plus memory wait to handler PC.

Reset
REQ-036 reset_n low SHALL immediately force pc=RESET_PC, epc=0, cause=0, state IDLE, vec_req=0, busy=0, sel_err=0.
REQ-037 Reset asserted mid-FETCH SHALL abort the vector read with no pc update.
REQ-038 First write SHALL take effect on the first rising edge after reset_n deasserts.

Structure
REQ-039 Package pc_ctrl_pkg SHALL hold the FSM state enum, cause codes and VEC_BASE=253.
REQ-040 Source selection SHALL be a sub-module pc_src_mux_n (parametrised WIDTH, NUM_SRC, combinational).

Verification
REQ-041 Reset, sel=2, src2=0x400, pc_write=1 -> pc=0x400 after one edge, sel_err=0.
REQ-042 pc_write_cond=1, cond=0 -> pc unchanged; cond=1 -> pc=src[sel].
REQ-043 pc=0x100, exc_req=3'b110 -> cause=1, epc=0xFC, vec_addr=254; vec_ack after 3 cycles with vec_data=0x80 -> pc=0x80, busy low.
REQ-044 NUM_SRC=5, sel=6, pc_write=1 -> pc unchanged, sel_err pulses once, mux_out=0.
REQ-045 pc=0, exc_req=3'b001 -> epc=0xFFFFFFFC; then eret in IDLE -> pc=0xFFFFFFFC.
REQ-046 reset_n low during FETCH -> vec_req=0, pc=RESET_PC immediately; late vec_ack ignored.
